// File: rtl/net2axis_player.sv
// net2axis_player -- memory-backed AXI4-Stream packet source.
//
// Replays a preloaded beat image packet by packet. Each packet is preceded by
// a descriptor that supplies its id and the number of idle cycles to insert
// before its first beat. A pass covers C_NUM_PKTS descriptors, or ends early
// when the last word of the beat memory has been sent. At the end of a pass,
// LOOP selects between replaying from packet 0 and stopping in DONE.
//
// Beat word layout : {tlast, tkeep[C_TDATA_WIDTH/8-1:0], tdata[C_TDATA_WIDTH-1:0]}
// Descriptor layout: {pkt_id[15:0], delay[15:0]}
//
// Ports
//   ACLK, ARESETN   clock, asynchronous active-low reset
//   START           one-cycle pulse, starts a run from IDLE or DONE
//   LOOP            sampled at each end of pass; 1 replays from packet 0
//   DONE            sticky, set when the final pass has completed
//   PKT_COUNT       packets fully sent since the last start (wraps)
//   CUR_PKT_ID      id of the packet currently delayed or streamed
//   M_AXIS_*        AXI4-Stream master; every output is a register
module net2axis_player #(
  parameter string       C_DATA_FILE   = "",
  parameter string       C_DESC_FILE   = "",
  parameter int unsigned C_TDATA_WIDTH = 32,
  parameter int unsigned C_DEPTH       = 1024,
  parameter int unsigned C_NUM_PKTS    = 16,
  parameter bit          C_AUTOSTART   = 1'b0
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic                       START,
  input  logic                       LOOP,
  output logic                       DONE,
  output logic [15:0]                PKT_COUNT,
  output logic [15:0]                CUR_PKT_ID,
  output logic                       M_AXIS_TVALID,
  output logic [C_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_TDATA_WIDTH/8-1:0] M_AXIS_TKEEP,
  output logic                       M_AXIS_TLAST,
  input  logic                       M_AXIS_TREADY
);

  localparam int unsigned KW = C_TDATA_WIDTH / 8;
  localparam int unsigned WW = 1 + KW + C_TDATA_WIDTH;
  localparam int unsigned AW = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;
  localparam int unsigned DW = (C_NUM_PKTS > 1) ? $clog2(C_NUM_PKTS) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(C_DEPTH - 1);
  localparam logic [15:0]   NUM_PKTS  = 16'(C_NUM_PKTS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_DELAY  = 3'd2,
    ST_STREAM = 3'd3,
    ST_NEXT   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  logic [WW-1:0] beat_mem [C_DEPTH];
  logic [31:0]   desc_mem [C_NUM_PKTS];

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] beat_ptr;
  logic [AW-1:0] beat_ptr_inc;
  logic [15:0]   desc_ptr;
  logic [15:0]   delay_cnt;
  logic          depth_end;
  logic          auto_pending;
  logic          handshake;
  logic          end_of_pass;
  logic [WW-1:0] cur_word;
  logic [WW-1:0] nxt_word;
  logic [31:0]   cur_desc;
  logic [DW-1:0] desc_idx;

  // The last memory word always closes its packet, so a missing tlast in the
  // image cannot run the beat pointer past the end of memory.
  function automatic logic [WW-1:0] force_last(input logic [WW-1:0] word,
                                               input logic          at_end);
    logic [WW-1:0] res;
    res         = word;
    res[WW-1]   = word[WW-1] | at_end;
    return res;
  endfunction

  assign beat_ptr_inc = beat_ptr + AW'(1);
  assign cur_word     = beat_mem[beat_ptr];
  assign nxt_word     = beat_mem[beat_ptr_inc];
  assign desc_idx     = desc_ptr[DW-1:0];
  assign cur_desc     = desc_mem[desc_idx];
  assign handshake    = M_AXIS_TVALID & M_AXIS_TREADY;
  assign end_of_pass  = (desc_ptr == NUM_PKTS) | depth_end;

  // State register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decision.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (START | auto_pending) state_next = ST_LOAD;
        else                      state_next = ST_IDLE;
      end
      ST_LOAD: begin
        if (cur_desc[15:0] == 16'd0) state_next = ST_STREAM;
        else                         state_next = ST_DELAY;
      end
      ST_DELAY: begin
        if (delay_cnt <= 16'd1) state_next = ST_STREAM;
        else                    state_next = ST_DELAY;
      end
      ST_STREAM: begin
        if (handshake & M_AXIS_TLAST) state_next = ST_NEXT;
        else                          state_next = ST_STREAM;
      end
      ST_NEXT: begin
        if (end_of_pass & ~LOOP) state_next = ST_DONE;
        else                     state_next = ST_LOAD;
      end
      ST_DONE: begin
        if (START) state_next = ST_LOAD;
        else       state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Pointers, counters and the registered stream outputs.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      beat_ptr      <= '0;
      desc_ptr      <= 16'd0;
      delay_cnt     <= 16'd0;
      depth_end     <= 1'b0;
      auto_pending  <= C_AUTOSTART;
      DONE          <= 1'b0;
      PKT_COUNT     <= 16'd0;
      CUR_PKT_ID    <= 16'd0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TKEEP  <= '0;
      M_AXIS_TLAST  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START | auto_pending) auto_pending <= 1'b0;
        end
        ST_LOAD: begin
          delay_cnt  <= cur_desc[15:0];
          CUR_PKT_ID <= cur_desc[31:16];
          {M_AXIS_TLAST, M_AXIS_TKEEP, M_AXIS_TDATA} <=
            force_last(cur_word, beat_ptr == LAST_ADDR);
          // Zero delay goes straight to streaming without an idle cycle.
          if (cur_desc[15:0] == 16'd0) M_AXIS_TVALID <= 1'b1;
        end
        ST_DELAY: begin
          delay_cnt <= delay_cnt - 16'd1;
          if (delay_cnt <= 16'd1) M_AXIS_TVALID <= 1'b1;
        end
        ST_STREAM: begin
          if (handshake) begin
            beat_ptr <= beat_ptr_inc;
            if (M_AXIS_TLAST) begin
              M_AXIS_TVALID <= 1'b0;
              PKT_COUNT     <= PKT_COUNT + 16'd1;
              desc_ptr      <= desc_ptr + 16'd1;
              depth_end     <= (beat_ptr == LAST_ADDR);
            end else begin
              // Fetch the following beat in the handshake cycle: no bubbles.
              {M_AXIS_TLAST, M_AXIS_TKEEP, M_AXIS_TDATA} <=
                force_last(nxt_word, beat_ptr_inc == LAST_ADDR);
            end
          end
        end
        ST_NEXT: begin
          if (end_of_pass) begin
            if (LOOP) begin
              beat_ptr  <= '0;
              desc_ptr  <= 16'd0;
              depth_end <= 1'b0;
            end else begin
              DONE <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (START) begin
            DONE      <= 1'b0;
            PKT_COUNT <= 16'd0;
            beat_ptr  <= '0;
            desc_ptr  <= 16'd0;
            depth_end <= 1'b0;
          end
        end
        default: begin
          M_AXIS_TVALID <= 1'b0;
        end
      endcase
    end
  end

endmodule
